// File: rtl/session_pkg.sv
// Shared types and helpers for the treadmill session sequencer.
// State encoding, phase codes, mm:ss BCD payload and the seconds-to-BCD converter.
package session_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned PHASE_W = 2;
   localparam int unsigned SPD_W   = 4;
   localparam int unsigned MIN_SEC = 1;
   localparam int unsigned MAX_SEC = 3599;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WARMUP = 3'd1,
      ST_RUN    = 3'd2,
      ST_COOL   = 3'd3,
      ST_PAUSED = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   localparam logic [PHASE_W-1:0] PH_IDLE   = 2'd0;
   localparam logic [PHASE_W-1:0] PH_WARMUP = 2'd1;
   localparam logic [PHASE_W-1:0] PH_RUN    = 2'd2;
   localparam logic [PHASE_W-1:0] PH_COOL   = 2'd3;

   // min1/sec1 are the tens digits
   typedef struct packed {
      logic [DIGIT_W-1:0] min1;
      logic [DIGIT_W-1:0] min2;
      logic [DIGIT_W-1:0] sec1;
      logic [DIGIT_W-1:0] sec2;
   } bcd_time_t;

   function automatic bcd_time_t sec_to_bcd(input int unsigned secs);
      int unsigned mins;
      int unsigned rem_s;
      bcd_time_t   t;
      mins   = secs / 60;
      rem_s  = secs % 60;
      t.min1 = DIGIT_W'(mins / 10);
      t.min2 = DIGIT_W'(mins % 10);
      t.sec1 = DIGIT_W'(rem_s / 10);
      t.sec2 = DIGIT_W'(rem_s % 10);
      return t;
   endfunction

   function automatic logic [PHASE_W-1:0] phase_of(input state_e st);
      logic [PHASE_W-1:0] ph;
      ph = PH_IDLE;
      case (st)
         ST_WARMUP: ph = PH_WARMUP;
         ST_RUN:    ph = PH_RUN;
         ST_COOL:   ph = PH_COOL;
         default:   ph = PH_IDLE;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/session_sequencer_if.sv
// Front-panel / timer / motor signal bundle of the session sequencer.
// Optional: SESSION_SAFETY_KEY_EN adds the safety_ok clip input.
interface session_sequencer_if;
   import session_pkg::*;

`ifdef SESSION_SAFETY_KEY_EN
   logic               safety_ok;
`endif
   logic               sec_tick;
   logic               start_btn;
   logic               pause_btn;
   logic               stop_btn;
   logic               timer_en;
   logic               timer_clr;
   logic [PHASE_W-1:0] phase;
   logic [SPD_W-1:0]   speed_level;
   logic [DIGIT_W-1:0] rem_min1;
   logic [DIGIT_W-1:0] rem_min2;
   logic [DIGIT_W-1:0] rem_sec1;
   logic [DIGIT_W-1:0] rem_sec2;
   logic               paused;
   logic               done;

   modport master (
`ifdef SESSION_SAFETY_KEY_EN
      output safety_ok,
`endif
      output sec_tick, start_btn, pause_btn, stop_btn,
      input  timer_en, timer_clr, phase, speed_level,
      input  rem_min1, rem_min2, rem_sec1, rem_sec2, paused, done
   );

   modport slave (
`ifdef SESSION_SAFETY_KEY_EN
      input  safety_ok,
`endif
      input  sec_tick, start_btn, pause_btn, stop_btn,
      output timer_en, timer_clr, phase, speed_level,
      output rem_min1, rem_min2, rem_sec1, rem_sec2, paused, done
   );

endinterface

// File: rtl/session_sequencer_bcd_countdown.sv
// Four-digit mm:ss BCD down-counter with synchronous load and an is-00:01 flag.
module bcd_countdown
   import session_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      load,
   input  bcd_time_t load_val,
   input  logic      dec,
   output bcd_time_t cnt,
   output logic      is_one_c
);

   bcd_time_t cnt_q, cnt_d;

   // Borrow ripples sec2 -> sec1 (mod 6) -> min2 -> min1
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec) begin
         if (cnt_q.sec2 != '0) begin
            cnt_d.sec2 = cnt_q.sec2 - DIGIT_W'(1);
         end else begin
            cnt_d.sec2 = DIGIT_W'(9);
            if (cnt_q.sec1 != '0) begin
               cnt_d.sec1 = cnt_q.sec1 - DIGIT_W'(1);
            end else begin
               cnt_d.sec1 = DIGIT_W'(5);
               if (cnt_q.min2 != '0) begin
                  cnt_d.min2 = cnt_q.min2 - DIGIT_W'(1);
               end else begin
                  cnt_d.min2 = DIGIT_W'(9);
                  cnt_d.min1 = cnt_q.min1 - DIGIT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt      = cnt_q;
   assign is_one_c = (cnt_q.min1 == '0) && (cnt_q.min2 == '0) &&
                     (cnt_q.sec1 == '0) && (cnt_q.sec2 == DIGIT_W'(1));

endmodule

// File: rtl/session_sequencer.sv
// Treadmill session sequencer: warm-up -> run -> cool-down with pause/stop and BCD countdown.
// Optional: SESSION_SAFETY_KEY_EN adds the safety_ok clip input and its forced abort.
module session_sequencer
   import session_pkg::*;
#(
   parameter int unsigned WARMUP_SEC = 120,
   parameter int unsigned RUN_SEC    = 600,
   parameter int unsigned COOL_SEC   = 120,
   parameter int unsigned WARMUP_SPD = 3,
   parameter int unsigned RUN_SPD    = 8,
   parameter int unsigned COOL_SPD   = 2
) (
   input logic            slow_clock,
   input logic            reset,
   session_sequencer_if.slave bus
);

   if (WARMUP_SEC < MIN_SEC || WARMUP_SEC > MAX_SEC) begin : g_bad_warmup
      $fatal(1, "session_sequencer: WARMUP_SEC out of range 1..3599");
   end
   if (RUN_SEC < MIN_SEC || RUN_SEC > MAX_SEC) begin : g_bad_run
      $fatal(1, "session_sequencer: RUN_SEC out of range 1..3599");
   end
   if (COOL_SEC < MIN_SEC || COOL_SEC > MAX_SEC) begin : g_bad_cool
      $fatal(1, "session_sequencer: COOL_SEC out of range 1..3599");
   end

   localparam bcd_time_t        WARMUP_LOAD = sec_to_bcd(WARMUP_SEC);
   localparam bcd_time_t        RUN_LOAD    = sec_to_bcd(RUN_SEC);
   localparam bcd_time_t        COOL_LOAD   = sec_to_bcd(COOL_SEC);
   localparam logic [SPD_W-1:0] WARMUP_LVL  = SPD_W'(WARMUP_SPD);
   localparam logic [SPD_W-1:0] RUN_LVL     = SPD_W'(RUN_SPD);
   localparam logic [SPD_W-1:0] COOL_LVL    = SPD_W'(COOL_SPD);

   state_e             state_q, state_d;
   state_e             saved_q, saved_d;
   logic               timer_en_q, timer_en_d;
   logic               timer_clr_q, timer_clr_d;
   logic               paused_q, paused_d;
   logic               done_q, done_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [SPD_W-1:0]   speed_q, speed_d;

   logic      cnt_load;
   logic      cnt_dec;
   bcd_time_t cnt_val;
   bcd_time_t rem;
   logic      is_one_c;

   logic active;
   logic abort;
   logic start_ok;

   assign active = (state_q == ST_WARMUP) || (state_q == ST_RUN) || (state_q == ST_COOL);

`ifdef SESSION_SAFETY_KEY_EN
   // A detached clip aborts any session in progress, ahead of stop
   assign abort    = (!bus.safety_ok && (active || state_q == ST_PAUSED)) ||
                     (bus.stop_btn && state_q != ST_IDLE);
   assign start_ok = bus.start_btn && bus.safety_ok;
`else
   assign abort    = bus.stop_btn && (state_q != ST_IDLE);
   assign start_ok = bus.start_btn;
`endif

   bcd_countdown u_countdown (
      .clk      (slow_clock),
      .rst_n    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .cnt      (rem),
      .is_one_c (is_one_c)
   );

   always_ff @(posedge slow_clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         saved_q     <= ST_IDLE;
         timer_en_q  <= 1'b0;
         timer_clr_q <= 1'b0;
         paused_q    <= 1'b0;
         done_q      <= 1'b0;
         phase_q     <= PH_IDLE;
         speed_q     <= '0;
      end else begin
         state_q     <= state_d;
         saved_q     <= saved_d;
         timer_en_q  <= timer_en_d;
         timer_clr_q <= timer_clr_d;
         paused_q    <= paused_d;
         done_q      <= done_d;
         phase_q     <= phase_d;
         speed_q     <= speed_d;
      end
   end

   // Next state and countdown control; priority abort > pause > start > tick
   always_comb begin
      state_d     = state_q;
      saved_d     = saved_q;
      timer_clr_d = 1'b0;
      cnt_load    = 1'b0;
      cnt_val     = '0;
      cnt_dec     = 1'b0;
      if (abort) begin
         state_d     = ST_IDLE;
         timer_clr_d = 1'b1;
         cnt_load    = 1'b1;
      end else if (bus.pause_btn && active) begin
         saved_d = state_q;
         state_d = ST_PAUSED;
      end else if (start_ok && (state_q == ST_IDLE || state_q == ST_DONE)) begin
         state_d     = ST_WARMUP;
         timer_clr_d = 1'b1;
         cnt_load    = 1'b1;
         cnt_val     = WARMUP_LOAD;
      end else if (bus.start_btn && state_q == ST_PAUSED) begin
         state_d = saved_q;
      end else if (bus.sec_tick && active) begin
         if (is_one_c) begin
            cnt_load = 1'b1;
            case (state_q)
               ST_WARMUP: begin
                  state_d = ST_RUN;
                  cnt_val = RUN_LOAD;
               end
               ST_RUN: begin
                  state_d = ST_COOL;
                  cnt_val = COOL_LOAD;
               end
               default: state_d = ST_DONE;
            endcase
         end else begin
            cnt_dec = 1'b1;
         end
      end
   end

   // Registered outputs are decoded from the upcoming state
   always_comb begin
      timer_en_d = 1'b0;
      paused_d   = 1'b0;
      done_d     = 1'b0;
      phase_d    = PH_IDLE;
      speed_d    = '0;
      case (state_d)
         ST_WARMUP: begin
            timer_en_d = 1'b1;
            phase_d    = PH_WARMUP;
            speed_d    = WARMUP_LVL;
         end
         ST_RUN: begin
            timer_en_d = 1'b1;
            phase_d    = PH_RUN;
            speed_d    = RUN_LVL;
         end
         ST_COOL: begin
            timer_en_d = 1'b1;
            phase_d    = PH_COOL;
            speed_d    = COOL_LVL;
         end
         ST_PAUSED: begin
            paused_d = 1'b1;
            phase_d  = phase_of(saved_d);
         end
         ST_DONE: done_d = 1'b1;
         default: ;
      endcase
   end

   assign bus.timer_en    = timer_en_q;
   assign bus.timer_clr   = timer_clr_q;
   assign bus.paused      = paused_q;
   assign bus.done        = done_q;
   assign bus.phase       = phase_q;
   assign bus.speed_level = speed_q;
   assign bus.rem_min1    = rem.min1;
   assign bus.rem_min2    = rem.min2;
   assign bus.rem_sec1    = rem.sec1;
   assign bus.rem_sec2    = rem.sec2;

endmodule

// File: tb/tb_session_sequencer.sv
// Bench for session_sequencer: two configurations driven in lockstep against a seconds-based model.
// Optional: SESSION_SAFETY_KEY_EN exercises the safety_ok clip input.
module tb_session_sequencer;

   logic slow_clock = 1'b0;
   logic reset      = 1'b1;

   session_sequencer_if bus_a();
   session_sequencer_if bus_b();

   session_sequencer #(
      .WARMUP_SEC(3), .RUN_SEC(5), .COOL_SEC(2),
      .WARMUP_SPD(3), .RUN_SPD(8), .COOL_SPD(2)
   ) dut_a (
      .slow_clock (slow_clock),
      .reset      (reset),
      .bus        (bus_a)
   );

   session_sequencer #(
      .WARMUP_SEC(1), .RUN_SEC(600), .COOL_SEC(1),
      .WARMUP_SPD(3), .RUN_SPD(8), .COOL_SPD(2)
   ) dut_b (
      .slow_clock (slow_clock),
      .reset      (reset),
      .bus        (bus_b)
   );

   always #5 slow_clock = ~slow_clock;

   int vectors     = 0;
   int miscompares = 0;

   // Model: 0 idle, 1 warm-up, 2 run, 3 cool-down, 4 paused, 5 done; remaining time in plain seconds
   int          m_st[2];
   int          m_saved[2];
   int unsigned m_rem[2];
   bit          m_clr[2];
   int unsigned m_len[2][4] = '{'{0, 3, 5, 2}, '{0, 1, 600, 1}};
   int unsigned m_spd[4]    = '{0, 3, 8, 2};
   bit          safety_v    = 1'b1;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 0; m_saved[i] = 0; m_rem[i] = 0; m_clr[i] = 1'b0;
      end
   endtask

   task automatic model_step(input int i, input bit t, input bit s, input bit p, input bit x, input bit sf);
      bit act;
      act      = (m_st[i] >= 1) && (m_st[i] <= 3);
      m_clr[i] = 1'b0;
      if ((!sf && (act || m_st[i] == 4)) || (x && m_st[i] != 0)) begin
         m_st[i] = 0; m_rem[i] = 0; m_clr[i] = 1'b1;
      end else if (p && act) begin
         m_saved[i] = m_st[i]; m_st[i] = 4;
      end else if (s && sf && (m_st[i] == 0 || m_st[i] == 5)) begin
         m_st[i] = 1; m_rem[i] = m_len[i][1]; m_clr[i] = 1'b1;
      end else if (s && m_st[i] == 4) begin
         m_st[i] = m_saved[i];
      end else if (t && act) begin
         if (m_rem[i] == 1) begin
            if (m_st[i] == 3) begin
               m_st[i] = 5; m_rem[i] = 0;
            end else begin
               m_st[i] = m_st[i] + 1; m_rem[i] = m_len[i][m_st[i]];
            end
         end else begin
            m_rem[i] = m_rem[i] - 1;
         end
      end
   endtask

   task automatic cmp(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s[%0d] at %0t: observed %0h expected %0h", tag, i, $time, obs, exp);
      end
   endtask

   function automatic logic [15:0] rem_of(input int i);
      if (i == 0) return {bus_a.rem_min1, bus_a.rem_min2, bus_a.rem_sec1, bus_a.rem_sec2};
      return {bus_b.rem_min1, bus_b.rem_min2, bus_b.rem_sec1, bus_b.rem_sec2};
   endfunction

   task automatic check_inst(input int i);
      logic        en, clr, pa, dn;
      logic [1:0]  ph;
      logic [3:0]  sp;
      bit          act;
      int unsigned mins, secs, e_ph, e_sp;
      if (i == 0) begin
         en = bus_a.timer_en; clr = bus_a.timer_clr; pa = bus_a.paused; dn = bus_a.done;
         ph = bus_a.phase;    sp  = bus_a.speed_level;
      end else begin
         en = bus_b.timer_en; clr = bus_b.timer_clr; pa = bus_b.paused; dn = bus_b.done;
         ph = bus_b.phase;    sp  = bus_b.speed_level;
      end
      act  = (m_st[i] >= 1) && (m_st[i] <= 3);
      e_ph = act ? m_st[i] : (m_st[i] == 4 ? m_saved[i] : 0);
      e_sp = act ? m_spd[m_st[i]] : 0;
      mins = m_rem[i] / 60;
      secs = m_rem[i] % 60;
      cmp("timer_en",  i, 16'(en),  16'(act));
      cmp("timer_clr", i, 16'(clr), 16'(m_clr[i]));
      cmp("paused",    i, 16'(pa),  16'(m_st[i] == 4));
      cmp("done",      i, 16'(dn),  16'(m_st[i] == 5));
      cmp("phase",     i, 16'(ph),  16'(e_ph));
      cmp("speed",     i, 16'(sp),  16'(e_sp));
      cmp("rem",       i, rem_of(i),
          {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)});
   endtask

   task automatic drive(input bit t, input bit s, input bit p, input bit x);
      bus_a.sec_tick = t; bus_a.start_btn = s; bus_a.pause_btn = p; bus_a.stop_btn = x;
      bus_b.sec_tick = t; bus_b.start_btn = s; bus_b.pause_btn = p; bus_b.stop_btn = x;
`ifdef SESSION_SAFETY_KEY_EN
      bus_a.safety_ok = safety_v;
      bus_b.safety_ok = safety_v;
`endif
   endtask

   // Apply one cycle of inputs, advance the model, check both instances after the edge
   task automatic step(input bit t, input bit s, input bit p, input bit x);
      drive(t, s, p, x);
      @(posedge slow_clock);
      model_step(0, t, s, p, x, safety_v);
      model_step(1, t, s, p, x, safety_v);
      #1;
      check_inst(0);
      check_inst(1);
   endtask

   initial begin
      bit t, s, p, x;
      drive(0, 0, 0, 0);
      model_reset();
      #2 reset = 1'b0;
      repeat (2) @(posedge slow_clock);
      #1;
      check_inst(0);
      check_inst(1);
      reset = 1'b1;

      // Full session; instance b shows the 10:00 -> 09:59 borrow on its first run tick
      step(0, 1, 0, 0);
      cmp("start_clr", 0, 16'(bus_a.timer_clr), 16'd1);
      cmp("warm_rem",  0, rem_of(0), 16'h0003);
      step(1, 0, 0, 0);
      cmp("b_run_load", 1, rem_of(1), 16'h1000);
      step(1, 0, 0, 0);
      cmp("b_borrow", 1, rem_of(1), 16'h0959);
      step(1, 0, 0, 0);
      cmp("run_rem", 0, rem_of(0), 16'h0005);
      repeat (5) step(1, 0, 0, 0);
      cmp("cool_rem", 0, rem_of(0), 16'h0002);
      repeat (2) step(1, 0, 0, 0);
      cmp("end_done", 0, 16'(bus_a.done),     16'd1);
      cmp("end_en",   0, 16'(bus_a.timer_en), 16'd0);

      // Pause in run with ticks dropped, then resume
      step(0, 1, 0, 0);
      repeat (5) step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      repeat (3) step(1, 0, 0, 0);
      cmp("pause_rem",   0, rem_of(0), 16'h0003);
      cmp("pause_speed", 0, 16'(bus_a.speed_level), 16'd0);
      cmp("pause_flag",  0, 16'(bus_a.paused), 16'd1);
      step(0, 1, 0, 0);
      cmp("resume_speed", 0, 16'(bus_a.speed_level), 16'd8);
      cmp("resume_phase", 0, 16'(bus_a.phase), 16'd2);
      step(0, 0, 0, 1);

      // Pause coinciding with warm-up expiry
      step(0, 1, 0, 0);
      repeat (2) step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      cmp("sim_paused", 0, 16'(bus_a.paused), 16'd1);
      cmp("sim_phase",  0, 16'(bus_a.phase),  16'd1);
      cmp("sim_rem",    0, rem_of(0), 16'h0001);
      step(0, 0, 0, 1);

      // Stop in cool-down coinciding with expiry
      step(0, 1, 0, 0);
      repeat (9) step(1, 0, 0, 0);
      step(1, 0, 0, 1);
      cmp("stop_clr", 0, 16'(bus_a.timer_clr), 16'd1);
      cmp("stop_rem", 0, rem_of(0), 16'h0000);

      // Asynchronous reset in the middle of run
      step(0, 1, 0, 0);
      repeat (4) step(1, 0, 0, 0);
      #3 reset = 1'b0;
      #1;
      model_reset();
      check_inst(0);
      check_inst(1);
      @(posedge slow_clock);
      #1;
      check_inst(0);
      check_inst(1);
      reset = 1'b1;

`ifdef SESSION_SAFETY_KEY_EN
      // Clip removed during run, then start refused while it stays off
      step(0, 1, 0, 0);
      repeat (4) step(1, 0, 0, 0);
      safety_v = 1'b0;
      step(0, 0, 0, 0);
      cmp("safety_clr",   0, 16'(bus_a.timer_clr), 16'd1);
      cmp("safety_phase", 0, 16'(bus_a.phase), 16'd0);
      step(0, 1, 0, 0);
      cmp("safety_nostart", 0, 16'(bus_a.timer_en), 16'd0);
      safety_v = 1'b1;
`endif

      // Long run on instance b: 10:00 down to 01:00, then 00:59
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      repeat (540) step(1, 0, 0, 0);
      cmp("b_min_edge", 1, rem_of(1), 16'h0100);
      step(1, 0, 0, 0);
      cmp("b_min_borrow", 1, rem_of(1), 16'h0059);

      // Randomized button/tick traffic
      repeat (600) begin
         t = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 9) == 0);
         p = ($urandom_range(0, 19) == 0);
         x = ($urandom_range(0, 39) == 0);
`ifdef SESSION_SAFETY_KEY_EN
         safety_v = ($urandom_range(0, 29) != 0);
`endif
         step(t, s, p, x);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
